// File: rtl/fft_mag_pkg.sv
// fft_mag_pkg
// Shared constants and types for the FFT magnitude writer.
//   FRAME_LEN   : complex samples per FFT frame
//   WR_BINS     : bins written to the magnitude RAM (0..WR_BINS-1)
//   ADDR_W      : RAM address width
//   DATA_W      : sample and magnitude width
//   MAG_SHIFT_B : first shift applied to min(|re|,|im|)  (x 1/4)
//   MAG_SHIFT_C : second shift applied to min(|re|,|im|) (x 1/8)
//   state_t     : writer frame-control states
package fft_mag_pkg;

    localparam int FRAME_LEN   = 256;
    localparam int WR_BINS     = 128;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;

    localparam int MAG_SHIFT_B = 2;
    localparam int MAG_SHIFT_C = 3;

    typedef enum logic [2:0] {
        ARMED,
        FILL,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/fft_mag_writer_if.sv
// fft_mag_writer_if
// Groups the sample stream and the magnitude-RAM write side of the writer.
//   s_valid/s_last/s_re/s_im : streamed complex FFT samples (producer -> writer)
//   s_ready                  : writer accepts samples
//   frame_ack                : reader has consumed the RAM (one-cycle pulse)
//   wr_en/wr_addr/wr_data    : magnitude RAM write port
//   wr_done                  : RAM holds a complete frame (level)
//   frame_err                : one-cycle framing error pulse
// Modports: master = stream source / reader side, slave = the writer.
interface fft_mag_writer_if;
    import fft_mag_pkg::*;

    logic              s_valid;
    logic              s_last;
    logic [DATA_W-1:0] s_re;
    logic [DATA_W-1:0] s_im;
    logic              s_ready;
    logic              frame_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              frame_err;

    modport master (
        output s_valid, s_last, s_re, s_im, frame_ack,
        input  s_ready, wr_en, wr_addr, wr_data, wr_done, frame_err
    );

    modport slave (
        input  s_valid, s_last, s_re, s_im, frame_ack,
        output s_ready, wr_en, wr_addr, wr_data, wr_done, frame_err
    );

endinterface

// File: rtl/fft_mag_writer_mag_approx.sv
// mag_approx
// Two-stage alpha-max-plus-beta-min magnitude pipeline with a valid/address
// sideband. Stage 1 registers |re| and |im|; stage 2 registers
// max + min/4 + min/8 onto the outputs.
//   clk_256k, rst_n : clock, asynchronous active-low reset
//   in_valid        : issue a write for this sample
//   in_addr         : bin index carried alongside the sample
//   in_re, in_im    : two's complement sample
//   out_valid       : write strobe, two cycles after in_valid
//   out_addr        : bin index of the write
//   out_data        : unsigned magnitude
module mag_approx
    import fft_mag_pkg::*;
(
    input  logic              clk_256k,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] mn;
    logic [DATA_W-1:0] mag;

    // Read unsigned, the negation of the most negative value is exactly
    // 2^(DATA_W-1), so no saturation is needed.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

    always_ff @(posedge clk_256k or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_addr <= in_addr;
                s1_a    <= abs_val(in_re);
                s1_b    <= abs_val(in_im);
            end
        end
    end

    // Largest result is 32768 + 8192 + 4096 = 45056, so the sum cannot
    // carry out of DATA_W bits.
    always_comb begin
        mx  = (s1_a >= s1_b) ? s1_a : s1_b;
        mn  = (s1_a >= s1_b) ? s1_b : s1_a;
        mag = mx + (mn >> MAG_SHIFT_B) + (mn >> MAG_SHIFT_C);
    end

    always_ff @(posedge clk_256k or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_addr <= s1_addr;
                out_data <= mag;
            end
        end
    end

endmodule

// File: rtl/fft_mag_writer.sv
// fft_mag_writer
// Producer side of the FFT magnitude buffer. Counts one streamed frame,
// writes the magnitudes of bins 0..WR_BINS-1 into the RAM, then holds
// wr_done until the reader acknowledges with frame_ack.
//   clk_256k : system clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave view of fft_mag_writer_if (sample stream + RAM writes)
module fft_mag_writer
    import fft_mag_pkg::*;
(
    input  logic              clk_256k,
    input  logic              rst_n,
    fft_mag_writer_if.slave   bus
);

    localparam int               IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W:0]   WR_LIMIT = (IDX_W + 1)'(WR_BINS);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             flush_cnt;
    logic             flush_cnt_next;
    logic             err_reg;
    logic             err_next;
    logic             accept;
    logic             wr_issue;

    // s_ready is gated by rst_n so it reads 0 while reset is held even
    // though the state register already sits in ARMED.
    assign bus.s_ready = rst_n && ((state == ARMED) || (state == FILL) || (state == DRAIN));
    assign accept      = bus.s_valid && bus.s_ready;
    assign wr_issue    = accept && ((state == ARMED) || (state == FILL)) && ({1'b0, idx} < WR_LIMIT);
    assign bus.wr_done   = (state == DONE);
    assign bus.frame_err = err_reg;

    mag_approx u_mag (
        .clk_256k  (clk_256k),
        .rst_n     (rst_n),
        .in_valid  (wr_issue),
        .in_addr   (ADDR_W'(idx)),
        .in_re     (bus.s_re),
        .in_im     (bus.s_im),
        .out_valid (bus.wr_en),
        .out_addr  (bus.wr_addr),
        .out_data  (bus.wr_data)
    );

    always_ff @(posedge clk_256k or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARMED;
            idx       <= '0;
            flush_cnt <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            flush_cnt <= flush_cnt_next;
            err_reg   <= err_next;
        end
    end

    // FLUSH lasts two cycles so the two pipeline stages drain before
    // wr_done rises; every exit from the frame clears idx for the next one.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        flush_cnt_next = flush_cnt;
        err_next       = 1'b0;
        case (state)
            ARMED: begin
                if (accept) begin
                    if (bus.s_last) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = FILL;
                        idx_next   = idx + IDX_W'(1);
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (bus.s_last) begin
                        idx_next = '0;
                        if (idx == LAST_IDX) begin
                            state_next     = FLUSH;
                            flush_cnt_next = 1'b0;
                        end else begin
                            state_next = ARMED;
                            err_next   = 1'b1;
                        end
                    end else if (idx == LAST_IDX) begin
                        state_next = DRAIN;
                        idx_next   = '0;
                        err_next   = 1'b1;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && bus.s_last) begin
                    state_next = ARMED;
                end
            end
            FLUSH: begin
                if (flush_cnt) begin
                    state_next = DONE;
                end else begin
                    flush_cnt_next = 1'b1;
                end
            end
            DONE: begin
                if (bus.frame_ack) begin
                    state_next = ARMED;
                end
            end
            default: begin
                state_next = ARMED;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: doc/fft_mag_writer.md
# fft_mag_writer

Producer side of the FFT magnitude buffer. Accepts one streamed complex FFT frame per acquisition and computes an alpha-max-plus-beta-min magnitude for each bin. It writes bins 0..WR_BINS-1 into the magnitude RAM, then raises `wr_done` to hand the RAM to the peak-search reader. It re-arms for the next frame only after the reader returns `frame_ack`.

## Interface
- `FRAME_LEN`, 256: complex samples per FFT frame.
- `WR_BINS`, 128: bins written to RAM (0..WR_BINS-1); must be ≤ FRAME_LEN.
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: sample and magnitude width.

Ports:
- `clk_256k` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low; clock `clk_256k`.
- `s_valid` input 1: FFT output sample valid.
- `s_last` input 1: marks the final sample of a frame; qualified by `s_valid`.
- `s_re` input DATA_W: real part, two's complement.
- `s_im` input DATA_W: imaginary part, two's complement.
- `s_ready` output 1: high when samples are accepted (states ARMED, FILL, DRAIN).
- `frame_ack` input 1: reader has consumed the RAM; single-cycle pulse.
- `wr_en` output 1: RAM write strobe.
- `wr_addr` output ADDR_W: RAM write address (bin index).
- `wr_data` output DATA_W: unsigned magnitude.
- `wr_done` output 1: level; RAM holds a complete frame.
- `frame_err` output 1: one-cycle pulse on a framing error.

## Operation
- A sample is accepted when `s_valid && s_ready`. The bin counter `idx` counts accepted samples 0..FRAME_LEN-1.
- Magnitude computation:
  - `a = |re|`, `b = |im|`, each as an unsigned DATA_W value. `|-32768|` = 32768; no saturation is needed.
  - `mag = max(a,b) + (min(a,b)>>2) + (min(a,b)>>3)`, computed at DATA_W+1 bits. Maximum value is 45056, so the result fits in DATA_W with no overflow.
- A write is issued only for `idx < WR_BINS`. Its address equals the `idx` captured at acceptance. Bins ≥ WR_BINS are computed but their writes are suppressed.
- States:
  - **ARMED**: `idx`=0, waiting for the first sample. An accepted sample moves to FILL. If that first sample also has `s_last` (frame length 1), fire `frame_err` and stay in ARMED.
  - **FILL**: counts samples.
    - `s_last` at `idx`==FRAME_LEN-1 → FLUSH.
    - `s_last` earlier → pulse `frame_err`, return to ARMED.
    - `idx`==FRAME_LEN-1 without `s_last` → pulse `frame_err`, go to DRAIN.
  - **DRAIN**: discards samples until an accepted `s_last`, then goes to ARMED. No writes are issued in this state.
  - **FLUSH**: 2 cycles so in-flight pipeline writes retire, then → DONE.
  - **DONE**: `wr_done`=1 and `s_ready`=0. `frame_ack` → ARMED; `wr_done` is 0 on the following cycle.
- `frame_ack` outside DONE is ignored.
- On an error exit, writes already in the pipeline still retire. The RAM contents are undefined, but `wr_done` stays 0.

## Timing
- Reset values: `s_ready`=0 during reset and 1 from the first cycle after release (state ARMED). `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_done`=0, `frame_err`=0, state ARMED, `idx`=0.
- Pipeline is 2 stages:
  - Stage 1: abs.
  - Stage 2: max/min/sum, registered onto `wr_*`.
  - A sample accepted at cycle n produces `wr_en`=1 at n+2.
- `wr_done` rises at cycle n+3, where n is the acceptance cycle of the valid `s_last`. This is after the last possible write (when WR_BINS==FRAME_LEN).
- `frame_err` is high for exactly one cycle, the cycle after the offending acceptance.
- Full throughput: one sample per cycle with no bubbles.
- Asynchronous reset mid-frame clears state and pipeline immediately. No further `wr_en` occurs until a new frame is accepted.

## Structure
- Package `fft_mag_pkg`:
  - FRAME_LEN, WR_BINS, ADDR_W, DATA_W defaults.
  - State enum (ARMED, FILL, DRAIN, FLUSH, DONE).
  - Magnitude coefficient shift constants (2, 3).
- Sub-module `mag_approx`: the 2-stage abs/max-min pipeline with a valid/address sideband. The parent holds the FSM and counters.

## Test plan
- Full frame of 256 samples with `re`=bin, `im`=0 → 128 writes, `wr_addr` 0..127, `wr_data`=bin. `wr_done`=1 at 3 cycles after `s_last`. No write to address ≥128.
- `re`=-32768, `im`=-32768 at bin 5 → `wr_data`[5]=45056.
- `re`=300, `im`=400 → `wr_data`=400+75+37=512.
- `s_last` at idx 100 → `frame_err` pulse, `wr_done` stays 0. The next full frame completes normally.
- No `s_last` at idx 255, `s_last` at 300 → `frame_err` pulse at idx 255+1 cycle. DRAIN drops samples until `s_last`, then ARMED with `s_ready`=1.
- Frame complete, then 10 extra `s_valid` cycles → no writes (`s_ready`=0). `frame_ack` pulse → `wr_done`=0 next cycle. `frame_ack` while ARMED → no effect. `rst_n` low mid-FILL → `wr_en` 0 immediately, all outputs at reset values.
